uart_tx_fifo_param: RTL and testbench

//   Parametrised UART serial transmitter, successor to the fixed 8N1 transmitter.

---
 rtl/uart_tx_fifo_param_if.sv | 25 ++
 rtl/uart_tx_fifo_param.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_tx_fifo_param.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_param_if.sv
// Write-side handshake and serial-side status of the buffered UART transmitter.
// The producer uses the master modport, the transmitter the slave modport.
interface uart_tx_fifo_param_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    logic                          i_DV;
    logic [DATA_BITS-1:0]          i_Byte;
    logic                          o_Ready;
    logic                          o_Overflow;
    logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count;
    logic                          o_Sig_Active;
    logic                          o_Serial_Data;
    logic                          o_Sig_Done;

    modport master (
        output i_DV, i_Byte,
        input  o_Ready, o_Overflow, o_Fifo_Count, o_Sig_Active, o_Serial_Data, o_Sig_Done
    );

    modport slave (
        input  i_DV, i_Byte,
        output o_Ready, o_Overflow, o_Fifo_Count, o_Sig_Active, o_Serial_Data, o_Sig_Done
    );
endinterface

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter: configurable width/parity/stop bits, fed by a small FIFO.
// Serial line, activity and done flags are registered one cycle behind the FSM state.
module uart_tx_fifo_param #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_tx_fifo_param_if.slave   tx
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = AW + 1;

    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CLK_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
    localparam logic [IW-1:0] IDX_ONE   = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [NW-1:0] CNT_ONE   = {{(NW-1){1'b0}}, 1'b1};
    localparam logic [NW-1:0] CNT_FULL  = NW'(FIFO_DEPTH);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_fifo_param: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_fifo_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_fifo_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_fifo_param: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo_param: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Odd mode makes the total count of ones, parity bit included, odd.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        if (PARITY == 1) begin
            parity_bit = ~^d;
        end else begin
            parity_bit = ^d;
        end
    endfunction

    logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_r, rd_ptr_r;
    logic [NW-1:0]        count_r, count_nx;
    logic                 ready_r, ovf_r;
    logic                 push_s, pop_s, empty_s;

    state_t               state_r, state_nx;
    logic [CW-1:0]        clk_cnt_r, clk_nx;
    logic [IW-1:0]        idx_r, idx_nx;
    logic [DATA_BITS-1:0] shift_r;
    logic                 bit_end_s, line_s, done_s;
    logic                 serial_r, active_r, done_r;

    assign push_s    = tx.i_DV & ready_r;
    assign empty_s   = (count_r == {NW{1'b0}});
    assign bit_end_s = (clk_cnt_r == CLK_LAST);

    // Occupancy after this cycle's push and pop.
    always_comb begin
        count_nx = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nx = count_r + CNT_ONE;
            2'b01:   count_nx = count_r - CNT_ONE;
            default: count_nx = count_r;
        endcase
    end

    // FIFO storage; pointers guard the contents so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= tx.i_Byte;
        end
    end

    // FIFO pointers, occupancy and write-side status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {NW{1'b0}};
            ready_r  <= 1'b1;
            ovf_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nx;
            ready_r <= (count_nx != CNT_FULL);
            ovf_r   <= tx.i_DV & ~ready_r;
        end
    end

    // Frame sequencing; idx_r counts data bits, then stop bits.
    always_comb begin
        state_nx = state_r;
        clk_nx   = clk_cnt_r;
        idx_nx   = idx_r;
        pop_s    = 1'b0;
        done_s   = 1'b0;
        line_s   = 1'b1;
        case (state_r)
            S_IDLE: begin
                if (!empty_s) begin
                    pop_s    = 1'b1;
                    state_nx = S_START;
                    clk_nx   = {CW{1'b0}};
                    idx_nx   = {IW{1'b0}};
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_START: begin
                line_s = 1'b0;
                if (bit_end_s) begin
                    state_nx = S_DATA;
                    clk_nx   = {CW{1'b0}};
                end else begin
                    clk_nx = clk_cnt_r + CLK_ONE;
                end
            end
            S_DATA: begin
                line_s = shift_r[idx_r];
                if (bit_end_s) begin
                    clk_nx = {CW{1'b0}};
                    if (idx_r == DATA_LAST) begin
                        idx_nx   = {IW{1'b0}};
                        state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_nx = idx_r + IDX_ONE;
                    end
                end else begin
                    clk_nx = clk_cnt_r + CLK_ONE;
                end
            end
            S_PARITY: begin
                line_s = parity_bit(shift_r);
                if (bit_end_s) begin
                    state_nx = S_STOP;
                    clk_nx   = {CW{1'b0}};
                end else begin
                    clk_nx = clk_cnt_r + CLK_ONE;
                end
            end
            S_STOP: begin
                line_s = 1'b1;
                if (bit_end_s) begin
                    clk_nx = {CW{1'b0}};
                    if (idx_r == STOP_LAST) begin
                        done_s = 1'b1;
                        idx_nx = {IW{1'b0}};
                        if (!empty_s) begin
                            pop_s    = 1'b1;
                            state_nx = S_START;
                        end else begin
                            state_nx = S_IDLE;
                        end
                    end else begin
                        idx_nx = idx_r + IDX_ONE;
                    end
                end else begin
                    clk_nx = clk_cnt_r + CLK_ONE;
                end
            end
            default: begin
                state_nx = S_IDLE;
                clk_nx   = {CW{1'b0}};
                idx_nx   = {IW{1'b0}};
            end
        endcase
    end

    // FSM state, bit timing counters and the shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            clk_cnt_r <= {CW{1'b0}};
            idx_r     <= {IW{1'b0}};
            shift_r   <= {DATA_BITS{1'b0}};
        end else begin
            state_r   <= state_nx;
            clk_cnt_r <= clk_nx;
            idx_r     <= idx_nx;
            if (pop_s) begin
                shift_r <= mem_r[rd_ptr_r];
            end
        end
    end

    // Registered line-side outputs; reset forces the line idle at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            serial_r <= 1'b1;
            active_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            serial_r <= line_s;
            active_r <= (state_r != S_IDLE);
            done_r   <= done_s;
        end
    end

    assign tx.o_Ready       = ready_r;
    assign tx.o_Overflow    = ovf_r;
    assign tx.o_Fifo_Count  = count_r;
    assign tx.o_Sig_Active  = active_r;
    assign tx.o_Serial_Data = serial_r;
    assign tx.o_Sig_Done    = done_r;
endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Scoreboard bench for three transmitter configurations: expected line frames are queued at
// stimulus time and a per-instance line monitor decodes and compares every frame it sees.
module tb_uart_tx_fifo_param;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   dn [3];
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    logic [15:0] q2 [$];

    always #5 clk = ~clk;

    uart_tx_fifo_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifa ();
    uart_tx_fifo_param_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) ifb ();
    uart_tx_fifo_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifc ();

    // A: 8E1, B: 7O1, C: 8N2
    uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
        dut_a (.clk(clk), .rst(rst), .tx(ifa.slave));
    uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
        dut_b (.clk(clk), .rst(rst), .tx(ifb.slave));
    uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4))
        dut_c (.clk(clk), .rst(rst), .tx(ifc.slave));

    logic [2:0] line_v, act_v;
    assign line_v = {ifc.o_Serial_Data, ifb.o_Serial_Data, ifa.o_Serial_Data};
    assign act_v  = {ifc.o_Sig_Active, ifb.o_Sig_Active, ifa.o_Sig_Active};

    // Done pulses per instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (ifa.o_Sig_Done === 1'b1) dn[0] = dn[0] + 1;
        if (ifb.o_Sig_Done === 1'b1) dn[1] = dn[1] + 1;
        if (ifc.o_Sig_Done === 1'b1) dn[2] = dn[2] + 1;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Must be called at a negedge; returns at the next negedge after the word was offered.
    task automatic push(input int k, input logic [8:0] d, input logic enq, input logic [15:0] e);
        case (k)
            0: begin ifa.i_DV = 1'b1; ifa.i_Byte = d[7:0]; if (enq) q0.push_back(e); end
            1: begin ifb.i_DV = 1'b1; ifb.i_Byte = d[6:0]; if (enq) q1.push_back(e); end
            default: begin ifc.i_DV = 1'b1; ifc.i_Byte = d[7:0]; if (enq) q2.push_back(e); end
        endcase
        @(negedge clk);
        ifa.i_DV = 1'b0;
        ifb.i_DV = 1'b0;
        ifc.i_DV = 1'b0;
    endtask

    task automatic wait_act(input int k, input logic lvl, input int max, input string nm);
        int t;
        t = 0;
        while (act_v[k] !== lvl && t < max) begin
            @(negedge clk);
            t++;
        end
        chk(nm, {31'd0, act_v[k]}, {31'd0, lvl});
    endtask

    // Waits for activity, then counts consecutive active cycles until it drops.
    task automatic wait_frame(input int k, output int run);
        wait_act(k, 1'b1, 40, "act_rise");
        run = 0;
        while (act_v[k] === 1'b1 && run < 1000) begin
            @(negedge clk);
            run++;
        end
        chk("act_fall", {31'd0, act_v[k]}, 32'd0);
    endtask

    // Decodes frames of nbits bits, each bit held for CPB cycles, and compares with the queue head.
    task automatic mon(input int k, input int nbits);
        logic [15:0] got, exp;
        logic        stable, abort, first;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && line_v[k] === 1'b0) begin
                got = 16'd0; stable = 1'b1; abort = 1'b0; first = 1'b0;
                case (k)
                    0: exp = (q0.size() > 0) ? q0.pop_front() : 16'hFFFF;
                    1: exp = (q1.size() > 0) ? q1.pop_front() : 16'hFFFF;
                    default: exp = (q2.size() > 0) ? q2.pop_front() : 16'hFFFF;
                endcase
                for (int b = 0; b < nbits; b++) begin
                    for (int c = 0; c < CPB; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (rst === 1'b1) abort = 1'b1;
                        if (!abort) begin
                            if (c == 0) first = line_v[k];
                            else if (line_v[k] !== first) stable = 1'b0;
                            got[b] = first;
                        end
                    end
                end
                if (!abort) chk($sformatf("frame%0d", k), {15'd0, stable, got}, {15'd0, 1'b1, exp});
                while (rst === 1'b1) @(negedge clk);
            end
        end
    endtask

    initial mon(0, 11);
    initial mon(1, 10);
    initial mon(2, 11);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int run, d0;
        dn[0] = 0; dn[1] = 0; dn[2] = 0;
        ifa.i_DV = 1'b0; ifa.i_Byte = 8'd0;
        ifb.i_DV = 1'b0; ifb.i_Byte = 7'd0;
        ifc.i_DV = 1'b0; ifc.i_Byte = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_line",   {31'd0, ifa.o_Serial_Data}, 32'd1);
        chk("rst_active", {31'd0, ifa.o_Sig_Active},  32'd0);
        chk("rst_ready",  {31'd0, ifa.o_Ready},       32'd1);
        chk("rst_count",  {29'd0, ifa.o_Fifo_Count},  32'd0);
        chk("rst_ovf",    {31'd0, ifa.o_Overflow},    32'd0);
        chk("rst_done",   {31'd0, ifa.o_Sig_Done},    32'd0);

        // Latency: word pushed at edge N, count back to 0 at N+1, line low from N+2.
        d0 = dn[0];
        push(0, 9'h055, 1'b1, {1'b1, 1'b0, 8'h55, 1'b0});
        chk("lat_cnt_n",   {29'd0, ifa.o_Fifo_Count}, 32'd1);
        chk("lat_line_n",  {31'd0, ifa.o_Serial_Data}, 32'd1);
        @(negedge clk);
        chk("lat_cnt_n1",  {29'd0, ifa.o_Fifo_Count}, 32'd0);
        chk("lat_line_n1", {31'd0, ifa.o_Serial_Data}, 32'd1);
        @(negedge clk);
        chk("lat_line_n2", {31'd0, ifa.o_Serial_Data}, 32'd0);
        wait_frame(0, run);
        chk("lat_done", dn[0] - d0, 32'd1);

        // 8E1 frame of 0xA5: 11 bits of 4 clocks, one done.
        d0 = dn[0];
        push(0, 9'h0A5, 1'b1, {1'b1, 1'b0, 8'hA5, 1'b0});
        wait_frame(0, run);
        chk("a5_len",  run, 32'd44);
        chk("a5_done", dn[0] - d0, 32'd1);

        // FIFO fill: four more words while the first is on the line, then one overflow.
        d0 = dn[0];
        push(0, 9'h011, 1'b1, {1'b1, 1'b0, 8'h11, 1'b0});
        wait_act(0, 1'b1, 20, "fill_act");
        push(0, 9'h001, 1'b1, {1'b1, 1'b1, 8'h01, 1'b0});
        push(0, 9'h007, 1'b1, {1'b1, 1'b1, 8'h07, 1'b0});
        push(0, 9'h080, 1'b1, {1'b1, 1'b1, 8'h80, 1'b0});
        push(0, 9'h0FE, 1'b1, {1'b1, 1'b1, 8'hFE, 1'b0});
        chk("full_cnt",   {29'd0, ifa.o_Fifo_Count}, 32'd4);
        chk("full_ready", {31'd0, ifa.o_Ready},      32'd0);
        push(0, 9'h066, 1'b0, 16'd0);
        chk("ovf_pulse",  {31'd0, ifa.o_Overflow},   32'd1);
        chk("ovf_cnt",    {29'd0, ifa.o_Fifo_Count}, 32'd4);
        @(negedge clk);
        chk("ovf_clear",  {31'd0, ifa.o_Overflow},   32'd0);
        wait_frame(0, run);
        chk("fill_done",  dn[0] - d0, 32'd5);
        chk("drain_ready", {31'd0, ifa.o_Ready},     32'd1);

        // 7O1 frames.
        d0 = dn[1];
        push(1, 9'h007, 1'b1, {1'b1, 1'b0, 7'h07, 1'b0});
        push(1, 9'h05A, 1'b1, {1'b1, 1'b1, 7'h5A, 1'b0});
        wait_frame(1, run);
        chk("b_len",  run, 32'd80);
        chk("b_done", dn[1] - d0, 32'd2);

        // 8N2 back-to-back: activity must stay high for both frames.
        d0 = dn[2];
        push(2, 9'h03C, 1'b1, {2'b11, 8'h3C, 1'b0});
        push(2, 9'h0C3, 1'b1, {2'b11, 8'hC3, 1'b0});
        wait_frame(2, run);
        chk("c_len",  run, 32'd88);
        chk("c_done", dn[2] - d0, 32'd2);

        // Reset in the middle of the data bits of 0xFF.
        push(0, 9'h0FF, 1'b1, {1'b1, 1'b0, 8'hFF, 1'b0});
        wait_act(0, 1'b1, 20, "abort_act");
        repeat (8) @(negedge clk);
        d0 = dn[0];
        rst = 1'b1;
        #1;
        chk("abort_line",   {31'd0, ifa.o_Serial_Data}, 32'd1);
        chk("abort_cnt",    {29'd0, ifa.o_Fifo_Count},  32'd0);
        chk("abort_active", {31'd0, ifa.o_Sig_Active},  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_nodone", dn[0] - d0, 32'd0);
        d0 = dn[0];
        push(0, 9'h03A, 1'b1, {1'b1, 1'b0, 8'h3A, 1'b0});
        wait_frame(0, run);
        chk("post_len",  run, 32'd44);
        chk("post_done", dn[0] - d0, 32'd1);

        repeat (4) @(negedge clk);
        chk("sb_empty_a", q0.size(), 32'd0);
        chk("sb_empty_b", q1.size(), 32'd0);
        chk("sb_empty_c", q2.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
